// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - parametrised N:1 registered mux with skid buffer, range error flag and beat counter
module mux_nx1_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     beat_cnt
);

  logic [WIDTH-1:0] w_word;
  logic             w_err;
  logic             w_accept;
  logic             w_deliver;
  logic             w_load;

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_err;
  logic             r_out_valid;

  logic [WIDTH-1:0] r_skid_data;
  logic [SEL_W-1:0] r_skid_sel;
  logic             r_skid_err;
  logic             r_skid_valid;

  logic [CNT_W-1:0] r_beat_cnt;

  // Channel selection; an unmatched select yields a zero word and raises err
  always_comb begin
    w_word = '0;
    w_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        w_word = in_data[k*WIDTH +: WIDTH];
        w_err  = 1'b0;
      end
    end
  end

  // in_ready depends only on the skid flop, so out_ready never reaches it combinationally
  assign in_ready  = ~r_skid_valid;
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = r_out_valid & out_ready;
  assign w_load    = ~r_out_valid | w_deliver;

  // Output stage and skid entry: flush, then refill from skid, then from input, else park in skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_sel   <= '0;
      r_skid_err   <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_load) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_sel    <= r_skid_sel;
        r_out_err    <= r_skid_err;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_data <= w_word;
          r_out_sel  <= in_sel;
          r_out_err  <= w_err;
        end
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_word;
      r_skid_sel   <= in_sel;
      r_skid_err   <= w_err;
    end
  end

  // Delivered-beat counter; wraps naturally and survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_deliver) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_err   = r_out_err;
  assign out_valid = r_out_valid;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb/tb_mux_nx1_pipe.sv - self-checking bench for mux_nx1_pipe with scoreboard
module tb_mux_nx1_pipe;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  sel;
    logic        err;
  } beat_t;

  logic clk;
  logic rst_n;

  logic          a_flush, a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready;
  logic [255:0]  a_in_data;
  logic [2:0]    a_in_sel, a_out_sel;
  logic [31:0]   a_out_data;
  logic [15:0]   a_beat_cnt;

  logic          b_flush, b_in_valid, b_in_ready, b_out_err, b_out_valid, b_out_ready;
  logic [191:0]  b_in_data;
  logic [2:0]    b_in_sel, b_out_sel;
  logic [31:0]   b_out_data;
  logic [3:0]    b_beat_cnt;

  int errors = 0;
  int checks = 0;

  beat_t q_a[$];
  beat_t q_b[$];

  mux_nx1_pipe #(.WIDTH(32), .N(8), .SEL_W(3), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_sel(a_out_sel), .out_err(a_out_err),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .beat_cnt(a_beat_cnt)
  );

  mux_nx1_pipe #(.WIDTH(32), .N(6), .SEL_W(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_sel(b_out_sel), .out_err(b_out_err),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .beat_cnt(b_beat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic beat_t exp_a(input logic [2:0] sel);
    beat_t b;
    b.data = 32'hA000_0000 + 32'(sel);
    b.sel  = sel;
    b.err  = 1'b0;
    return b;
  endfunction

  function automatic beat_t exp_b(input logic [2:0] sel);
    beat_t b;
    b.sel  = sel;
    b.err  = (sel >= 3'd6);
    b.data = b.err ? 32'h0 : (32'hB000_0000 + 32'(sel));
    return b;
  endfunction

  // scoreboard for instance A
  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL sb_a_unexpected: got data=%h sel=%0d, required no beat", a_out_data, a_out_sel);
        end else begin
          beat_t e;
          e = q_a.pop_front();
          if (a_out_data !== e.data || a_out_sel !== e.sel || a_out_err !== e.err) begin
            errors++;
            $display("FAIL sb_a_beat: got data=%h sel=%0d err=%b, required data=%h sel=%0d err=%b",
                     a_out_data, a_out_sel, a_out_err, e.data, e.sel, e.err);
          end
        end
      end
      if (a_flush) q_a.delete();
      else if (a_in_valid && a_in_ready) q_a.push_back(exp_a(a_in_sel));
    end
  end

  // scoreboard for instance B
  always @(negedge clk) begin
    if (!rst_n) begin
      q_b.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL sb_b_unexpected: got data=%h sel=%0d, required no beat", b_out_data, b_out_sel);
        end else begin
          beat_t e;
          e = q_b.pop_front();
          if (b_out_data !== e.data || b_out_sel !== e.sel || b_out_err !== e.err) begin
            errors++;
            $display("FAIL sb_b_beat: got data=%h sel=%0d err=%b, required data=%h sel=%0d err=%b",
                     b_out_data, b_out_sel, b_out_err, e.data, e.sel, e.err);
          end
        end
      end
      if (b_flush) q_b.delete();
      else if (b_in_valid && b_in_ready) q_b.push_back(exp_b(b_in_sel));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_sel = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_sel = 0; b_out_ready = 0;
    for (int k = 0; k < 8; k++) a_in_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    for (int k = 0; k < 6; k++) b_in_data[k*32 +: 32] = 32'hB000_0000 + 32'(k);
    #12;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_out_sel !== 3'd0 || a_out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got valid=%b data=%h sel=%0d err=%b, required all 0", a_out_valid, a_out_data, a_out_sel, a_out_err);
    end
    checks++;
    if (a_beat_cnt !== 16'd0 || b_beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt: got a=%0d b=%0d, required 0 0", a_beat_cnt, b_beat_cnt);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got a=%b b=%b, required 1 1", a_in_ready, b_in_ready);
    end
    tick();
  endtask

  task automatic test_sweep();
    a_out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      a_in_sel = 3'(s);
      a_in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL sweep_in_ready: got %b at sel %0d, required 1", a_in_ready, s);
      end
      if (s > 0) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'hA000_0000 + 32'(s - 1) || a_out_err !== 1'b0) begin
          errors++;
          $display("FAIL sweep_latency: got valid=%b data=%h err=%b, required 1 %h 0",
                   a_out_valid, a_out_data, a_out_err, 32'hA000_0000 + 32'(s - 1));
        end
      end
      tick();
    end
    a_in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (a_beat_cnt !== 16'd8) begin
      errors++;
      $display("FAIL sweep_cnt: got %0d, required 8", a_beat_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] cnt0;
    a_out_ready = 1'b0;
    cnt0 = a_beat_cnt;
    a_in_sel = 3'd2; a_in_valid = 1'b1;
    tick();
    a_in_sel = 3'd5;
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== 32'hA000_0002) begin
        errors++;
        $display("FAIL bp_hold: got in_ready=%b valid=%b data=%h, required 0 1 a0000002", a_in_ready, a_out_valid, a_out_data);
      end
      tick();
    end
    a_out_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 32'hA000_0005 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got valid=%b data=%h in_ready=%b, required 1 a0000005 1", a_out_valid, a_out_data, a_in_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_beat_cnt !== cnt0 + 16'd2) begin
      errors++;
      $display("FAIL bp_cnt: got valid=%b cnt=%0d, required 0 %0d", a_out_valid, a_beat_cnt, cnt0 + 16'd2);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [2:0] seq [4];
    seq = '{3'd7, 3'd1, 3'd6, 3'd5};
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_sel = seq[i];
      b_in_valid = 1'b1;
      tick();
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'h0 || b_out_err !== 1'b1 || b_out_sel !== 3'd7) begin
          errors++;
          $display("FAIL oor_flag: got valid=%b data=%h err=%b sel=%0d, required 1 0 1 7", b_out_valid, b_out_data, b_out_err, b_out_sel);
        end
      end else if (i == 1) begin
        @(negedge clk);
        checks++;
        if (b_out_data !== 32'hB000_0001 || b_out_err !== 1'b0 || b_out_sel !== 3'd1) begin
          errors++;
          $display("FAIL oor_next: got data=%h err=%b sel=%0d, required b0000001 0 1", b_out_data, b_out_err, b_out_sel);
        end
      end
    end
    b_in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_flush();
    logic [15:0] cnt0;
    a_out_ready = 1'b0;
    a_in_sel = 3'd3; a_in_valid = 1'b1;
    tick();
    a_in_sel = 3'd4;
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    cnt0 = a_beat_cnt;
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_full: got in_ready=%b, required 0", a_in_ready);
    end
    tick();
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_sel = 3'd6;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_beat_cnt !== cnt0) begin
      errors++;
      $display("FAIL flush_clear: got valid=%b in_ready=%b cnt=%0d, required 0 1 %0d", a_out_valid, a_in_ready, a_beat_cnt, cnt0);
    end
    tick();
    // one beat held, flush while a new beat is accepted into the skid slot
    a_in_sel = 3'd1; a_in_valid = 1'b1;
    tick();
    a_flush = 1'b1; a_in_sel = 3'd6;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_accept_ready: got %b, required 1", a_in_ready);
    end
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_dropped: got out_valid=%b data=%h, required 0", a_out_valid, a_out_data);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0;
    a_in_sel = 3'd1; a_in_valid = 1'b1;
    tick();
    a_in_sel = 3'd7;
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_out_sel !== 3'd0 || a_out_err !== 1'b0) begin
      errors++;
      $display("FAIL async_out: got valid=%b data=%h sel=%0d err=%b, required all 0", a_out_valid, a_out_data, a_out_sel, a_out_err);
    end
    checks++;
    if (a_beat_cnt !== 16'd0 || b_beat_cnt !== 4'd0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_cnt: got a=%0d b=%0d in_ready=%b, required 0 0 1", a_beat_cnt, b_beat_cnt, a_in_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    tick();
  endtask

  task automatic test_counter_wrap();
    b_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (b_beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL wrap_start: got %0d, required 0", b_beat_cnt);
    end
    tick();
    for (int p = 1; p <= 18; p++) begin
      b_in_valid = (p <= 17);
      b_in_sel = 3'((p - 1) % 6);
      tick();
      // after edge p, p-1 beats have been delivered
      if (p == 16 || p == 17 || p == 18) begin
        logic [3:0] want;
        want = (p == 16) ? 4'd15 : (p == 17) ? 4'd0 : 4'd1;
        checks++;
        if (b_beat_cnt !== want) begin
          errors++;
          $display("FAIL wrap_cnt: after %0d deliveries got %0d, required %0d", p - 1, b_beat_cnt, want);
        end
      end
    end
    b_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_drain();
    tick();
    tick();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending a=%0d b=%0d, required 0 0", q_a.size(), q_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_backpressure();
    test_out_of_range();
    test_flush();
    test_async_reset();
    test_counter_wrap();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised N:1, WIDTH-bit multiplexer with a registered output and a valid/ready handshake.
- Generalises the existing 8:1 single-bit gate-level selector:
  - width and channel count are configurable;
  - one-cycle pipelining is added;
  - a skid entry gives full-throughput backpressure;
  - out-of-range selects are flagged;
  - delivered beats are counted.
- Used in the datapath wherever a selected operand must cross a pipeline-stage boundary, for example writeback source selection and forwarding selection.

Parameters:
- WIDTH, 32, data bits per channel.
- N, 8, number of input channels (N >= 2).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= N.
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all buffered beats.
- in_data  input  N*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH]; channel 0 is in the LSBs.
- in_sel  input  SEL_W  channel select, sampled with the beat.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat this cycle.
- out_data  output  WIDTH  selected word.
- out_sel  output  SEL_W  select value that produced out_data.
- out_err  output  1  in_sel was >= N for this beat.
- out_valid  output  1  out_* fields hold a beat.
- out_ready  input  1  downstream accepts.
- beat_cnt  output  CNT_W  count of delivered beats.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid, out_data, out_sel, out_err, the skid entry (valid/data/sel/err) and beat_cnt all go to 0.
  - in_ready is 1 from the first cycle after release.
- Handshake rules:
  - accept = in_valid & in_ready.
  - deliver = out_valid & out_ready.
  - in_ready = ~skid_valid, driven from a flop with no combinational path from out_ready.
  - Once asserted, out_valid stays high and out_data/out_sel/out_err stay stable until deliver.
- Selection:
  - word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < N.
  - When in_sel >= N: word = 0 and err = 1.
  - word, in_sel and err are captured together as one beat.
- Per-cycle update, in priority order:
  1. flush: out_valid <= 0 and skid_valid <= 0. Any beat accepted in the same cycle is dropped. beat_cnt still increments if deliver is also true that cycle.
  2. Output empty or deliver, with skid_valid: output <= skid entry, skid_valid <= 0.
  3. Output empty or deliver, without skid: output <= accepted beat; out_valid <= accept.
  4. Output full, no deliver, accept: beat goes to skid; skid_valid <= 1, so in_ready drops the next cycle.
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid when the path is unstalled.
  - Sustained throughput is 1 beat/cycle while out_ready stays high.
  - At most 2 beats are buffered.
- Ordering: beats leave in acceptance order, with no loss or duplication except on flush.
- beat_cnt increments by 1 on each deliver and wraps from 2**CNT_W-1 to 0. flush does not clear it; only reset does.
- Reset asserted mid-stream discards all buffered beats immediately.
- Combinational paths: no combinational path from in_* to out_*, and none from out_ready to in_ready.

Test Plan:
- Reset then sweep: N=8, WIDTH=32, channel k = 32'hA000_0000+k, out_ready=1, in_sel 0..7 in consecutive cycles -> out_data A000_0000..A000_0007 one cycle later each, out_err=0, beat_cnt=8, in_ready stays 1.
- Backpressure: out_ready=0, send sel=2 then sel=5 -> out holds channel 2; in_ready=0 after the second beat. Then raise out_ready -> channel 2 is delivered, then channel 5 on the next cycle; in_ready returns to 1; beat_cnt=2.
- Out-of-range: N=6, SEL_W=3, in_sel=7 -> out_data=0, out_err=1, out_sel=7. The following beat with sel=1 delivers channel 1 with out_err=0.
- Flush with 2 beats buffered (out_ready=0): pulse flush -> out_valid=0 and in_ready=1 next cycle; beat_cnt unchanged. A beat offered during the flush cycle is never delivered.
- Async reset: assert rst_n low mid-stall, between clock edges -> outputs and beat_cnt read 0 before the next clk edge.
- Counter wrap: CNT_W=4, 17 deliveries -> beat_cnt reads 15 after the 15th delivery, 0 after the 16th, and 1 after the 17th.
